irq_sequencer: RTL and testbench



---
 rtl/irq_pkg.sv | 17 +
 rtl/irq_prio_arbiter.sv | 27 ++
 rtl/irq_sequencer.sv | 129 ++++++++++++
 tb/tb_irq_sequencer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt entry/return sequencer.
//   irq_state_t        : sequencer FSM states
//   MCAUSE_INT_BIT     : interrupt flag in mcause
//   CAUSE_BASE_DEFAULT : mcause code for interrupt line 0
package irq_pkg;

  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_ENTRY   = 2'd1,
    IRQ_HANDLER = 2'd2,
    IRQ_RETURN  = 2'd3
  } irq_state_t;

  localparam logic [31:0] MCAUSE_INT_BIT     = 32'h8000_0000;
  localparam int          CAUSE_BASE_DEFAULT = 16;

endpackage

// File: rtl/irq_prio_arbiter.sv
// Fixed-priority arbiter over eligible interrupt lines. Lowest index wins.
//   req    in  NUM_IRQ  eligible lines (pending & mask)
//   valid  out 1        any request present
//   id     out ID_W     index of the winning line
//   onehot out NUM_IRQ  winning line as a one-hot vector
module irq_prio_arbiter #(
  parameter  int NUM_IRQ = 4,
  localparam int ID_W    = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [ID_W-1:0]    id,
  output logic [NUM_IRQ-1:0] onehot
);

  always_comb begin
    valid = |req;
    id    = '0;
    // Scan high to low so the lowest set index is the last assignment.
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (req[k]) id = ID_W'(k);
    end
    // Isolate the lowest set bit.
    onehot = req & (~req + NUM_IRQ'(1));
  end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt entry/return sequencer for the 5-stage pipeline.
// Captures rising edges on the interrupt lines, arbitrates by fixed priority,
// and sequences a precise trap (flush ID/EX, write mepc/mcause, redirect to the
// handler) and the mret return (flush, redirect to the saved mepc).
//   i_clk, i_reset                  clock, synchronous active-high reset
//   i_irq, i_irq_mask, i_mie        lines, per-line enable, global enable
//   i_mtvec                         trap vector (bit0 = vectored)
//   i_restore_pc                    hazard-unit redirect this cycle (defers entry)
//   i_ex/id_valid, i_ex/id/if_pc    stage validity and PCs
//   i_ex_mret                       valid mret in EX
//   o_flush_ID/EX (active-low), o_pc_enable, o_redirect_en/pc,
//   o_mepc_wren/o_mepc/o_mcause, o_irq_ack (one-hot), o_in_handler
module irq_sequencer
  import irq_pkg::*;
#(
  parameter int NUM_IRQ    = 4,
  parameter int CAUSE_BASE = CAUSE_BASE_DEFAULT
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic [NUM_IRQ-1:0] i_irq_mask,
  input  logic               i_mie,
  input  logic [31:0]        i_mtvec,
  input  logic               i_restore_pc,
  input  logic               i_ex_valid,
  input  logic               i_id_valid,
  input  logic [31:0]        i_ex_pc,
  input  logic [31:0]        i_id_pc,
  input  logic [31:0]        i_if_pc,
  input  logic               i_ex_mret,
  output logic               o_flush_ID,
  output logic               o_flush_EX,
  output logic               o_pc_enable,
  output logic               o_redirect_en,
  output logic [31:0]        o_redirect_pc,
  output logic               o_mepc_wren,
  output logic [31:0]        o_mepc,
  output logic [31:0]        o_mcause,
  output logic [NUM_IRQ-1:0] o_irq_ack,
  output logic               o_in_handler
);

  localparam int ID_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  irq_state_t         state;
  logic [NUM_IRQ-1:0] prev_irq, pending, cur_oh, ack;
  logic [ID_W-1:0]    cur_id;
  logic [31:0]        saved_mepc, live_pc, vec_base;
  logic               arb_valid;
  logic [ID_W-1:0]    arb_id;
  logic [NUM_IRQ-1:0] arb_oh;

  irq_prio_arbiter #(.NUM_IRQ(NUM_IRQ)) u_arb (
    .req    (pending & i_irq_mask),
    .valid  (arb_valid),
    .id     (arb_id),
    .onehot (arb_oh)
  );

  // Oldest instruction still in flight is the one to resume at.
  assign live_pc  = i_ex_valid ? i_ex_pc : (i_id_valid ? i_id_pc : i_if_pc);
  assign vec_base = i_mtvec & 32'hFFFF_FFFC;
  assign ack      = (state == IRQ_ENTRY) ? cur_oh : '0;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IRQ_IDLE;
      prev_irq   <= '0;
      pending    <= '0;
      cur_id     <= '0;
      cur_oh     <= '0;
      saved_mepc <= '0;
    end else begin
      prev_irq <= i_irq;
      // A new edge on the line being acked re-arms it (set wins).
      pending  <= (pending & ~ack) | (i_irq & ~prev_irq);
      case (state)
        IRQ_IDLE: begin
          if (arb_valid && i_mie && !i_restore_pc) begin
            state  <= IRQ_ENTRY;
            cur_id <= arb_id;
            cur_oh <= arb_oh;
          end
        end
        IRQ_ENTRY: begin
          saved_mepc <= live_pc;
          state      <= IRQ_HANDLER;
        end
        IRQ_HANDLER: if (i_ex_mret) state <= IRQ_RETURN;
        IRQ_RETURN:  state <= IRQ_IDLE;
        default:     state <= IRQ_IDLE;
      endcase
    end
  end

  always_comb begin
    o_flush_ID    = 1'b1;
    o_flush_EX    = 1'b1;
    o_pc_enable   = 1'b1;  // redirect overrides any stall, so never gate the PC
    o_redirect_en = 1'b0;
    o_redirect_pc = '0;
    o_mepc_wren   = 1'b0;
    o_mepc        = '0;
    o_mcause      = '0;
    o_irq_ack     = ack;
    o_in_handler  = 1'b0;
    case (state)
      IRQ_ENTRY: begin
        o_flush_ID    = 1'b0;
        o_flush_EX    = 1'b0;
        o_redirect_en = 1'b1;
        o_redirect_pc = i_mtvec[0] ? vec_base + (32'(cur_id) << 2) : vec_base;
        o_mepc_wren   = 1'b1;
        o_mepc        = live_pc;
        o_mcause      = MCAUSE_INT_BIT | 32'(CAUSE_BASE + cur_id);
      end
      IRQ_HANDLER: o_in_handler = 1'b1;
      IRQ_RETURN: begin
        o_flush_ID    = 1'b0;
        o_flush_EX    = 1'b0;
        o_redirect_en = 1'b1;
        o_redirect_pc = saved_mepc;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed bench for irq_sequencer: inputs change 1 time unit after the rising
// edge, outputs are sampled on the falling edge.
module tb_irq_sequencer;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [3:0]  i_irq, i_irq_mask, o_irq_ack;
  logic        i_mie, i_restore_pc, i_ex_valid, i_id_valid, i_ex_mret;
  logic [31:0] i_mtvec, i_ex_pc, i_id_pc, i_if_pc;
  logic        o_flush_ID, o_flush_EX, o_pc_enable, o_redirect_en, o_mepc_wren, o_in_handler;
  logic [31:0] o_redirect_pc, o_mepc, o_mcause;

  int n_tests = 0;
  int n_fail  = 0;

  irq_sequencer #(.NUM_IRQ(4), .CAUSE_BASE(16)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_irq(i_irq), .i_irq_mask(i_irq_mask),
    .i_mie(i_mie), .i_mtvec(i_mtvec), .i_restore_pc(i_restore_pc),
    .i_ex_valid(i_ex_valid), .i_id_valid(i_id_valid), .i_ex_pc(i_ex_pc),
    .i_id_pc(i_id_pc), .i_if_pc(i_if_pc), .i_ex_mret(i_ex_mret),
    .o_flush_ID(o_flush_ID), .o_flush_EX(o_flush_EX), .o_pc_enable(o_pc_enable),
    .o_redirect_en(o_redirect_en), .o_redirect_pc(o_redirect_pc),
    .o_mepc_wren(o_mepc_wren), .o_mepc(o_mepc), .o_mcause(o_mcause),
    .o_irq_ack(o_irq_ack), .o_in_handler(o_in_handler)
  );

  always #5 i_clk = ~i_clk;

  task automatic cyc();
    @(posedge i_clk);
    #1;
  endtask

  task automatic smp();
    @(negedge i_clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full idle/default output check.
  task automatic chk_idle(input string tag);
    chk({tag, ".flush"}, {30'd0, o_flush_ID, o_flush_EX}, 32'd3);
    chk({tag, ".pcen"},  {31'd0, o_pc_enable}, 32'd1);
    chk({tag, ".redir"}, {31'd0, o_redirect_en}, 32'd0);
    chk({tag, ".wren"},  {31'd0, o_mepc_wren}, 32'd0);
    chk({tag, ".ack"},   {28'd0, o_irq_ack}, 32'd0);
  endtask

  task automatic chk_entry(input string tag, input logic [31:0] rpc, input logic [31:0] mepc,
                           input logic [31:0] cause, input logic [3:0] ack);
    chk({tag, ".flush"}, {30'd0, o_flush_ID, o_flush_EX}, 32'd0);
    chk({tag, ".pcen"},  {31'd0, o_pc_enable}, 32'd1);
    chk({tag, ".redir"}, {31'd0, o_redirect_en}, 32'd1);
    chk({tag, ".wren"},  {31'd0, o_mepc_wren}, 32'd1);
    chk({tag, ".rpc"},   o_redirect_pc, rpc);
    chk({tag, ".mepc"},  o_mepc, mepc);
    chk({tag, ".cause"}, o_mcause, cause);
    chk({tag, ".ack"},   {28'd0, o_irq_ack}, {28'd0, ack});
  endtask

  task automatic chk_ret(input string tag, input logic [31:0] rpc);
    chk({tag, ".flush"}, {30'd0, o_flush_ID, o_flush_EX}, 32'd0);
    chk({tag, ".redir"}, {31'd0, o_redirect_en}, 32'd1);
    chk({tag, ".rpc"},   o_redirect_pc, rpc);
    chk({tag, ".wren"},  {31'd0, o_mepc_wren}, 32'd0);
    chk({tag, ".inh"},   {31'd0, o_in_handler}, 32'd0);
  endtask

  // From HANDLER: assert mret for one cycle, check RETURN, then IDLE.
  task automatic do_return(input string tag, input logic [31:0] rpc);
    cyc(); i_ex_mret = 1'b1; smp();
    chk({tag, ".hnd"}, {31'd0, o_in_handler}, 32'd1);
    cyc(); i_ex_mret = 1'b0; smp();
    chk_ret({tag, ".ret"}, rpc);
    cyc(); smp();
    chk_idle({tag, ".idle"});
  endtask

  initial begin
    i_reset = 1'b1; i_irq = '0; i_irq_mask = 4'hF; i_mie = 1'b1; i_mtvec = 32'h100;
    i_restore_pc = 1'b0; i_ex_valid = 1'b1; i_id_valid = 1'b0; i_ex_mret = 1'b0;
    i_ex_pc = 32'h40; i_id_pc = 32'h0; i_if_pc = 32'h0;
    cyc(); cyc();
    i_reset = 1'b0;
    smp();
    chk_idle("rst");
    chk("rst.rpc",   o_redirect_pc, 32'h0);
    chk("rst.mepc",  o_mepc, 32'h0);
    chk("rst.cause", o_mcause, 32'h0);
    chk("rst.inh",   {31'd0, o_in_handler}, 32'd0);

    // Single interrupt, direct vector.
    cyc(); i_irq = 4'b0100; smp(); chk_idle("t1.c0");
    cyc(); smp(); chk_idle("t1.c1");
    cyc(); smp(); chk_entry("t1.ent", 32'h100, 32'h40, 32'h8000_0012, 4'b0100);
    cyc(); smp();
    chk("t1.hnd.inh", {31'd0, o_in_handler}, 32'd1);
    chk_idle("t1.hnd");
    do_return("t1", 32'h40);

    // Priority + vectored, then back-to-back entry of the held line.
    cyc(); i_irq = 4'b1010; i_mtvec = 32'h201; i_ex_pc = 32'h50; smp();
    cyc(); smp(); chk_idle("t2.c1");
    cyc(); smp(); chk_entry("t2.ent1", 32'h204, 32'h50, 32'h8000_0011, 4'b0010);
    cyc(); i_ex_pc = 32'h54; smp();
    do_return("t2a", 32'h50);
    cyc(); smp(); chk_entry("t2.ent3", 32'h20C, 32'h54, 32'h8000_0013, 4'b1000);
    cyc(); smp();
    do_return("t2b", 32'h54);

    // Branch conflict defers entry by one cycle.
    cyc(); i_irq = 4'b0001; i_mtvec = 32'h100; smp();
    cyc(); i_restore_pc = 1'b1; smp(); chk_idle("t3.def");
    cyc(); i_restore_pc = 1'b0; i_ex_pc = 32'h60; smp(); chk_idle("t3.late");
    cyc(); smp(); chk_entry("t3.ent", 32'h100, 32'h60, 32'h8000_0010, 4'b0001);
    cyc(); smp();
    do_return("t3", 32'h60);

    // Bubble in EX: mepc from ID, then from IF.
    cyc(); i_irq = 4'b0010; i_ex_valid = 1'b0; i_id_valid = 1'b1; i_id_pc = 32'h80; smp();
    cyc(); smp();
    cyc(); smp(); chk_entry("t4.id", 32'h100, 32'h80, 32'h8000_0011, 4'b0010);
    cyc(); smp();
    do_return("t4a", 32'h80);
    cyc(); i_irq = 4'b0110; i_id_valid = 1'b0; i_if_pc = 32'h90; smp();
    cyc(); smp();
    cyc(); smp(); chk_entry("t4.if", 32'h100, 32'h90, 32'h8000_0012, 4'b0100);
    cyc(); smp();
    do_return("t4b", 32'h90);

    // Masked by mie, then nested line held during HANDLER.
    cyc(); i_mie = 1'b0; i_irq = 4'b1110; smp();
    cyc(); smp(); chk_idle("t5.m1");
    cyc(); smp(); chk_idle("t5.m2");
    cyc(); smp(); chk_idle("t5.m3");
    cyc(); i_mie = 1'b1; i_if_pc = 32'hA0; smp(); chk_idle("t5.en");
    cyc(); smp(); chk_entry("t5.ent", 32'h100, 32'hA0, 32'h8000_0013, 4'b1000);
    cyc(); i_irq = 4'b1111; smp();
    chk("t5.hnd1", {31'd0, o_in_handler}, 32'd1);
    cyc(); smp(); chk("t5.held.inh", {31'd0, o_in_handler}, 32'd1); chk_idle("t5.held");
    cyc(); smp(); chk_idle("t5.held2");
    do_return("t5", 32'hA0);
    cyc(); smp(); chk_entry("t5.ent0", 32'h100, 32'hA0, 32'h8000_0010, 4'b0001);

    // Reset in HANDLER drops the trap and a pending line.
    cyc(); i_irq = 4'b0000; smp();
    chk("t6.hnd", {31'd0, o_in_handler}, 32'd1);
    cyc(); i_irq = 4'b0010; smp();
    cyc(); i_reset = 1'b1; i_irq = 4'b0000; smp();
    cyc(); i_reset = 1'b0; smp();
    chk_idle("t6.rst");
    chk("t6.rst.inh", {31'd0, o_in_handler}, 32'd0);
    chk("t6.rst.rpc", o_redirect_pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      cyc(); smp();
      chk_idle("t6.drop");
      chk("t6.drop.inh", {31'd0, o_in_handler}, 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
